// File: rtl/enc_pkg.sv
// Shared types and helpers for the sequential priority encoder.
package enc_pkg;

    // Controller state: IDLE accepts a new vector, BUSY serves its bits.
    typedef enum logic [0:0] {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_e;

    // Ceiling log2, usable in constant (parameter) expressions.
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned result;
        result = 0;
        while ((32'd1 << result) < value) begin
            result = result + 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/prio_enc.sv
// Combinational priority encoder over the pending vector: picks the lowest
// (or highest, with MSB_FIRST) set bit and flags when only one bit remains.
module prio_enc
    import enc_pkg::*;
#(
    parameter int unsigned N         = 8,
    parameter bit          MSB_FIRST = 1'b0,
    localparam int unsigned W        = clog2(N)
) (
    input  logic [N-1:0] pend,
    output logic [W-1:0] idx,
    output logic [N-1:0] onehot,
    output logic         single
);

    // Scan order makes the last match win: ascending scan keeps the highest
    // set bit, descending scan keeps the lowest.
    always_comb begin
        idx = '0;
        if (MSB_FIRST) begin
            for (int i = 0; i < N; i++) begin
                if (pend[i]) begin
                    idx = W'(i);
                end
            end
        end else begin
            for (int i = N - 1; i >= 0; i--) begin
                if (pend[i]) begin
                    idx = W'(i);
                end
            end
        end
    end

    // Decode and single-bit detection; all zero when nothing is pending.
    always_comb begin
        onehot = (pend != '0) ? (N'(1) << idx) : '0;
        single = (pend != '0) && ((pend & (pend - N'(1))) == '0);
    end

endmodule

// File: rtl/seq_priority_encoder.sv
// Sequential priority encoder: accepts a request vector, then emits one
// valid/ready beat per set bit in priority order, tagging the final beat.
module seq_priority_encoder
    import enc_pkg::*;
#(
    parameter int unsigned N         = 8,
    parameter bit          MSB_FIRST = 1'b0,
    localparam int unsigned W        = clog2(N)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         req_valid,
    output logic         req_ready,
    input  logic [N-1:0] req_vec,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_idx,
    output logic [N-1:0] out_onehot,
    output logic         out_last,
    output logic [W:0]   out_seq
);

    state_e         state_q, state_d;
    logic [N-1:0]   pend_q, pend_d;
    logic [W:0]     seq_q, seq_d;

    logic [W-1:0]   enc_idx;
    logic [N-1:0]   enc_onehot;
    logic           enc_single;

    prio_enc #(
        .N         (N),
        .MSB_FIRST (MSB_FIRST)
    ) u_prio_enc (
        .pend   (pend_q),
        .idx    (enc_idx),
        .onehot (enc_onehot),
        .single (enc_single)
    );

    // State, pending bits and beat counter; reset drops any partial vector.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            pend_q  <= '0;
            seq_q   <= '0;
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
            seq_q   <= seq_d;
        end
    end

    // Next state: load on a nonzero accept, retire one bit per handshake.
    always_comb begin
        state_d = state_q;
        pend_d  = pend_q;
        seq_d   = seq_q;
        unique case (state_q)
            IDLE: begin
                // A zero vector is accepted and dropped without any beat.
                if (req_valid && (req_vec != '0)) begin
                    pend_d  = req_vec;
                    seq_d   = '0;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                // req_valid/req_vec are ignored here; one vector at a time.
                if (out_ready) begin
                    pend_d = pend_q & ~enc_onehot;
                    seq_d  = seq_q + {{W{1'b0}}, 1'b1};
                    if (enc_single) begin
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Outputs decode registered state only, so no input reaches an output.
    always_comb begin
        req_ready  = (state_q == IDLE);
        out_valid  = (state_q == BUSY);
        out_idx    = (state_q == BUSY) ? enc_idx : '0;
        out_onehot = (state_q == BUSY) ? enc_onehot : '0;
        out_last   = (state_q == BUSY) && enc_single;
        out_seq    = seq_q;
    end

endmodule

// File: tb/tb_seq_priority_encoder.sv
// Bench for seq_priority_encoder: an LSB-first and an MSB-first instance
// share all inputs; expected beats are queued on accept and popped on
// each output handshake.
module tb_seq_priority_encoder;

    localparam int unsigned N  = 8;
    localparam int unsigned W  = 3;
    localparam int unsigned SW = W + 1;

    typedef struct packed {
        logic [W-1:0]  idx;
        logic [N-1:0]  onehot;
        logic          last;
        logic [SW-1:0] seq;
    } beat_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          req_valid = 1'b0;
    logic [N-1:0]  req_vec = '0;
    logic          out_ready = 1'b0;

    logic          req_ready_l, out_valid_l, out_last_l;
    logic [W-1:0]  out_idx_l;
    logic [N-1:0]  out_onehot_l;
    logic [SW-1:0] out_seq_l;

    logic          req_ready_m, out_valid_m, out_last_m;
    logic [W-1:0]  out_idx_m;
    logic [N-1:0]  out_onehot_m;
    logic [SW-1:0] out_seq_m;

    int n_tests = 0;
    int n_fail  = 0;

    beat_t exp_l[$];
    beat_t exp_m[$];

    always #5 clk = ~clk;

    seq_priority_encoder #(
        .N         (N),
        .MSB_FIRST (1'b0)
    ) dut_lsb (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready_l),
        .req_vec    (req_vec),
        .out_valid  (out_valid_l),
        .out_ready  (out_ready),
        .out_idx    (out_idx_l),
        .out_onehot (out_onehot_l),
        .out_last   (out_last_l),
        .out_seq    (out_seq_l)
    );

    seq_priority_encoder #(
        .N         (N),
        .MSB_FIRST (1'b1)
    ) dut_msb (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready_m),
        .req_vec    (req_vec),
        .out_valid  (out_valid_m),
        .out_ready  (out_ready),
        .out_idx    (out_idx_m),
        .out_onehot (out_onehot_m),
        .out_last   (out_last_m),
        .out_seq    (out_seq_m)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expected beat stream for both serving orders.
    function automatic void push_model(input logic [N-1:0] vec);
        beat_t b;
        int    cnt;
        int    k;
        cnt = $countones(vec);
        k = 0;
        for (int i = 0; i < N; i++) begin
            if (vec[i]) begin
                b.idx    = W'(i);
                b.onehot = N'(1) << i;
                b.last   = (k == cnt - 1);
                b.seq    = SW'(k);
                exp_l.push_back(b);
                k++;
            end
        end
        k = 0;
        for (int i = N - 1; i >= 0; i--) begin
            if (vec[i]) begin
                b.idx    = W'(i);
                b.onehot = N'(1) << i;
                b.last   = (k == cnt - 1);
                b.seq    = SW'(k);
                exp_m.push_back(b);
                k++;
            end
        end
    endfunction

    // Offer one vector for a single cycle and queue its expected beats.
    task automatic send(input logic [N-1:0] vec);
        req_vec   = vec;
        req_valid = 1'b1;
        n_tests++;
        if (req_ready_l !== 1'b1 || req_ready_m !== 1'b1) begin
            n_fail++;
            $display("FAIL accept_ready vec=%h: req_ready=%b/%b, required 1",
                     vec, req_ready_l, req_ready_m);
        end
        push_model(vec);
        tick();
        req_valid = 1'b0;
    endtask

    // Consume beats, comparing each against the scoreboard; optional 0/1
    // ready toggling with a stability check across each stall.
    task automatic serve_beats(input string name, input int max_cycles, input bit toggle,
                               input int max_beats, output int beats);
        beat_t obs_l, obs_m, prev_l, prev_m, e;
        bit    stalled;
        bit    done;
        int    cyc;
        beats   = 0;
        stalled = 1'b0;
        done    = 1'b0;
        cyc     = 0;
        prev_l  = '0;
        prev_m  = '0;
        while (!done && beats < max_beats && cyc < max_cycles) begin
            out_ready = toggle ? ((cyc % 2) == 1) : 1'b1;
            obs_l = '{out_idx_l, out_onehot_l, out_last_l, out_seq_l};
            obs_m = '{out_idx_m, out_onehot_m, out_last_m, out_seq_m};
            if (out_valid_l || out_valid_m) begin
                n_tests++;
                if (req_ready_l !== 1'b0 || req_ready_m !== 1'b0 ||
                    out_valid_l !== 1'b1 || out_valid_m !== 1'b1) begin
                    n_fail++;
                    $display("FAIL %s busy_flags: valid=%b/%b ready=%b/%b, required 1/1 0/0",
                             name, out_valid_l, out_valid_m, req_ready_l, req_ready_m);
                end
                if (stalled) begin
                    n_tests++;
                    if (obs_l !== prev_l || obs_m !== prev_m) begin
                        n_fail++;
                        $display("FAIL %s stall_stable: got %h/%h, required %h/%h",
                                 name, obs_l, obs_m, prev_l, prev_m);
                    end
                end
                if (out_ready) begin
                    n_tests++;
                    if (exp_l.size() == 0 || exp_m.size() == 0) begin
                        n_fail++;
                        $display("FAIL %s extra_beat: got %h/%h, required no beat",
                                 name, obs_l, obs_m);
                    end else begin
                        e = exp_l.pop_front();
                        if (obs_l !== e) begin
                            n_fail++;
                            $display("FAIL %s beat_lsb[%0d]: got %h, required %h",
                                     name, beats, obs_l, e);
                        end
                        e = exp_m.pop_front();
                        n_tests++;
                        if (obs_m !== e) begin
                            n_fail++;
                            $display("FAIL %s beat_msb[%0d]: got %h, required %h",
                                     name, beats, obs_m, e);
                        end
                    end
                    beats++;
                    if (out_last_l) begin
                        done = 1'b1;
                    end
                    stalled = 1'b0;
                end else begin
                    prev_l  = obs_l;
                    prev_m  = obs_m;
                    stalled = 1'b1;
                end
            end
            tick();
            cyc++;
        end
        if (!done && beats < max_beats) begin
            n_tests++;
            n_fail++;
            $display("FAIL %s timeout: %0d beats after %0d cycles, required completion",
                     name, beats, cyc);
        end
    endtask

    // Common end-of-vector check: idle again, scoreboard drained.
    task automatic check_idle(input string name, input int beats, input int want_beats);
        n_tests++;
        if (beats != want_beats) begin
            n_fail++;
            $display("FAIL %s beat_count: got %0d, required %0d", name, beats, want_beats);
        end
        n_tests++;
        if (req_ready_l !== 1'b1 || req_ready_m !== 1'b1 ||
            out_valid_l !== 1'b0 || out_valid_m !== 1'b0) begin
            n_fail++;
            $display("FAIL %s back_idle: ready=%b/%b valid=%b/%b, required 1/1 0/0",
                     name, req_ready_l, req_ready_m, out_valid_l, out_valid_m);
        end
        n_tests++;
        if (exp_l.size() != 0 || exp_m.size() != 0) begin
            n_fail++;
            $display("FAIL %s leftover: %0d/%0d expected beats unseen, required 0/0",
                     name, exp_l.size(), exp_m.size());
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        n_tests++;
        if (out_valid_l !== 1'b0 || out_idx_l !== '0 || out_onehot_l !== '0 ||
            out_last_l !== 1'b0 || out_seq_l !== '0 || req_ready_l !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_state: v=%b i=%h oh=%h l=%b s=%h r=%b, required 0 0 0 0 0 1",
                     out_valid_l, out_idx_l, out_onehot_l, out_last_l, out_seq_l, req_ready_l);
        end
        rst = 1'b0;
    endtask

    task automatic test_lsb_basic();
        int beats;
        send(8'b1010_0100);
        n_tests++;
        if (out_valid_l !== 1'b1) begin
            n_fail++;
            $display("FAIL lsb_latency: out_valid=%b, required 1", out_valid_l);
        end
        serve_beats("lsb_basic", 20, 1'b0, 100, beats);
        check_idle("lsb_basic", beats, 3);
    endtask

    task automatic test_msb_first();
        int beats;
        send(8'b1010_0100);
        n_tests++;
        if (out_idx_m !== 3'd7 || out_onehot_m !== 8'h80) begin
            n_fail++;
            $display("FAIL msb_first_beat: idx=%0d oh=%h, required 7 80", out_idx_m, out_onehot_m);
        end
        serve_beats("msb_first", 20, 1'b0, 100, beats);
        check_idle("msb_first", beats, 3);
    endtask

    task automatic test_all_ones_stall();
        int beats;
        send(8'hFF);
        serve_beats("all_ones", 40, 1'b1, 100, beats);
        check_idle("all_ones", beats, 8);
    endtask

    task automatic test_zero_vector();
        send(8'h00);
        for (int i = 0; i < 3; i++) begin
            n_tests++;
            if (out_valid_l !== 1'b0 || out_valid_m !== 1'b0 ||
                req_ready_l !== 1'b1 || req_ready_m !== 1'b1) begin
                n_fail++;
                $display("FAIL zero_vec[%0d]: valid=%b/%b ready=%b/%b, required 0/0 1/1",
                         i, out_valid_l, out_valid_m, req_ready_l, req_ready_m);
            end
            tick();
        end
    endtask

    task automatic test_reset_mid_vector();
        int beats;
        send(8'h0F);
        serve_beats("rst_mid", 20, 1'b0, 2, beats);
        #2;
        rst = 1'b1;
        #1;
        n_tests++;
        if (out_valid_l !== 1'b0 || out_idx_l !== '0 || out_onehot_l !== '0 ||
            out_last_l !== 1'b0 || out_seq_l !== '0 || req_ready_l !== 1'b1 ||
            out_valid_m !== 1'b0 || out_onehot_m !== '0 || out_seq_m !== '0) begin
            n_fail++;
            $display("FAIL rst_mid_outputs: v=%b i=%h oh=%h l=%b s=%h r=%b, required 0 0 0 0 0 1",
                     out_valid_l, out_idx_l, out_onehot_l, out_last_l, out_seq_l, req_ready_l);
        end
        exp_l.delete();
        exp_m.delete();
        tick();
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_tests++;
            if (out_valid_l !== 1'b0 || out_valid_m !== 1'b0) begin
                n_fail++;
                $display("FAIL rst_mid_quiet[%0d]: valid=%b/%b, required 0/0",
                         i, out_valid_l, out_valid_m);
            end
        end
        send(8'h10);
        serve_beats("rst_new", 20, 1'b0, 100, beats);
        check_idle("rst_new", beats, 1);
    endtask

    task automatic test_ignore_while_busy();
        int beats;
        send(8'h06);
        req_valid = 1'b1;
        req_vec   = 8'hF0;
        serve_beats("ignore_busy", 20, 1'b0, 100, beats);
        req_valid = 1'b0;
        check_idle("ignore_busy", beats, 2);
        tick();
        n_tests++;
        if (out_valid_l !== 1'b0 || out_valid_m !== 1'b0) begin
            n_fail++;
            $display("FAIL ignore_busy_after: valid=%b/%b, required 0/0",
                     out_valid_l, out_valid_m);
        end
    endtask

    initial begin
        test_reset();
        test_lsb_basic();
        test_msb_first();
        test_all_ones_stall();
        test_zero_vector();
        test_reset_mid_vector();
        test_ignore_while_busy();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/seq_priority_encoder.md
SEQ_PRIORITY_ENCODER -- requirements
Module: seq_priority_encoder

Interface
REQ-001 The block SHALL have parameter N, default 8, meaning the request vector width; N >= 2.
REQ-002 The block SHALL have parameter MSB_FIRST, default 0, meaning 0 serves the lowest set index first and 1 serves the highest.
REQ-003 The block SHALL have derived localparam W = clog2(N), meaning the index width.
REQ-004 The block SHALL have port clk  input  1  meaning the single clock; all state changes on its rising edge.
REQ-005 The block SHALL have port rst  input  1  meaning asynchronous active-high reset.
REQ-006 The block SHALL have port req_valid  input  1  meaning a request vector is offered.
REQ-007 The block SHALL have port req_ready  output  1  meaning the block accepts a vector this cycle.
REQ-008 The block SHALL have port req_vec  input  N  meaning the request bits.
REQ-009 The block SHALL have port out_valid  output  1  meaning an encoded beat is present.
REQ-010 The block SHALL have port out_ready  input  1  meaning the consumer takes the beat.
REQ-011 The block SHALL have port out_idx  output  W  meaning the binary index of the served bit.
REQ-012 The block SHALL have port out_onehot  output  N  meaning the one-hot decode of out_idx.
REQ-013 The block SHALL have port out_last  output  1  meaning the final beat of the current vector.
REQ-014 The block SHALL have port out_seq  output  W+1  meaning the beat number within the vector, starting at 0.

Function
REQ-015 The block SHALL have two states, IDLE and BUSY, held in a state register.
REQ-016 In IDLE, req_ready SHALL be 1; in BUSY, req_ready SHALL be 0; no overlap between vectors.
REQ-017 An accept (req_valid & req_ready) of a nonzero req_vec SHALL load the pending register pend <= req_vec, clear out_seq, and move to BUSY.
REQ-018 An accept of req_vec == 0 SHALL be consumed with no output beat, and the block SHALL remain in IDLE.
REQ-019 In BUSY, out_valid SHALL be 1; out_valid SHALL be 1 on the cycle after an accept, giving 1-cycle latency.
REQ-020 out_idx SHALL be the lowest set index of pend when MSB_FIRST=0, or the highest set index when MSB_FIRST=1.
REQ-021 out_onehot SHALL be 1 << out_idx in BUSY and 0 in IDLE.
REQ-022 out_last SHALL be 1 exactly when pend has a single bit set.
REQ-023 Outputs SHALL depend only on registered state (pend, state, seq), with no combinational input-to-output path.
REQ-024 On a handshake (out_valid & out_ready), the served bit SHALL be cleared in pend and out_seq SHALL increment.
REQ-025 On a handshake with out_last=1, the block SHALL return to IDLE, and req_ready SHALL be 1 on the next cycle.
REQ-026 While out_valid=1 and out_ready=0, out_idx, out_onehot, out_last and out_seq SHALL hold stable.
REQ-027 The all-ones vector SHALL produce exactly N beats, with out_seq running 0..N-1.
REQ-028 req_valid and req_vec SHALL be ignored while in BUSY.

Reset
REQ-029 rst=1 SHALL asynchronously force IDLE, pend=0, out_seq=0, out_valid=0, out_idx=0, out_onehot=0, out_last=0 and req_ready=1 (from the IDLE decode).
REQ-030 Reset asserted mid-vector SHALL discard the remaining pending bits, with no beat after reset release until a new accept.
REQ-031 The first accept SHALL be possible on the first rising edge after rst deasserts.

Structure
REQ-032 A shared package enc_pkg SHALL hold the state enum (IDLE, BUSY) and the clog2 helper function.
REQ-033 The block SHALL contain one sub-module, prio_enc (parametrised N and MSB_FIRST), which is combinational: pend in; idx, onehot and single-bit flag out.
REQ-034 The FSM, pend register and seq counter SHALL live in seq_priority_encoder.

Verification
REQ-035 The bench SHALL cover: N=8, MSB_FIRST=0, req_vec=8'b1010_0100, out_ready=1 -> beats idx 2,5,7; seq 0,1,2; out_last only on idx 7; req_ready=1 the following cycle.
REQ-036 The bench SHALL cover: MSB_FIRST=1, same vector -> idx 7,5,2; onehot 8'h80, 8'h20, 8'h04.
REQ-037 The bench SHALL cover: req_vec=8'hFF, with out_ready toggled 1/0 every cycle -> 8 beats idx 0..7, outputs stable during each stall, seq ends at 7.
REQ-038 The bench SHALL cover: req_vec=8'h00 accepted -> out_valid stays 0 and req_ready stays 1.
REQ-039 The bench SHALL cover: req_vec=8'h0F, with rst pulsed after the 2nd beat -> all outputs 0 immediately, no further beats; a new vector 8'h10 -> single beat idx 4, last=1.
REQ-040 The bench SHALL cover: req_valid held with a new vector during BUSY -> the vector is ignored, and the current vector's beats are unaffected.
